// File: rtl/shift_frame_pkg.sv
// Shared definitions for the shift frame sequencer: FSM encoding and width helper.
package shift_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ceil(log2(value)), never less than 1 so a counter always has a bit
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((32'd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/shift_frame_core.sv
// Tx/rx shift registers of the frame sequencer; bit order selected by SHIFT_LSB_FIRST_EN
// (undefined: MSB first with left shifts, defined: LSB first with right shifts).
module shift_frame_core
  import shift_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic              i_d,
  input  logic [DATA_W-1:0] par_in,
  output logic              tx_ser,
  output logic [DATA_W-1:0] rx_par
);

  logic [DATA_W-1:0] tx_r;
  logic [DATA_W-1:0] rx_r;
  logic [DATA_W-1:0] tx_shift_s;
  logic [DATA_W-1:0] rx_shift_s;

  // Next shifted values and the serial tap for the selected bit order
  always_comb begin
`ifdef SHIFT_LSB_FIRST_EN
    tx_shift_s = {1'b0, tx_r[DATA_W-1:1]};
    rx_shift_s = {i_d, rx_r[DATA_W-1:1]};
    tx_ser     = tx_r[0];
`else
    tx_shift_s = {tx_r[DATA_W-2:0], 1'b0};
    rx_shift_s = {rx_r[DATA_W-2:0], i_d};
    tx_ser     = tx_r[DATA_W-1];
`endif
  end

  // Load clears rx so a new frame never inherits bits from an aborted one
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_r <= '0;
      rx_r <= '0;
    end else if (load) begin
      tx_r <= par_in;
      rx_r <= '0;
    end else if (shift_en) begin
      tx_r <= tx_shift_s;
      rx_r <= rx_shift_s;
    end else begin
      tx_r <= tx_r;
      rx_r <= rx_r;
    end
  end

  assign rx_par = rx_r;

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer: valid/ready word in, serial shift out/in, captured word out.
// Bit order follows SHIFT_LSB_FIRST_EN (see shift_frame_core).
module shift_frame_ctrl
  import shift_frame_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic              i_d,
  output logic              o_q,
  output logic              o_frame,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy
);

  localparam int DIV_W = clog2_min1(CLK_DIV);
  localparam int CNT_W = clog2_min1(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_r;
  logic [DIV_W-1:0]  div_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              frame_r;
  logic              busy_r;
  logic              rx_valid_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              load_s;
  logic              shift_en_s;
  logic              tx_ser_s;
  logic [DATA_W-1:0] rx_par_s;

  assign o_tx_ready = (state_r == ST_IDLE);
  assign load_s     = i_tx_valid & o_tx_ready;
  assign shift_en_s = (state_r == ST_SHIFT) && (div_r == DIV_LAST);

  shift_frame_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (load_s),
    .shift_en(shift_en_s),
    .i_d     (i_d),
    .par_in  (i_tx_data),
    .tx_ser  (tx_ser_s),
    .rx_par  (rx_par_s)
  );

  // Frame FSM with divider, bit counter and registered status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      div_r      <= '0;
      cnt_r      <= '0;
      frame_r    <= 1'b0;
      busy_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rx_valid_r <= 1'b0;
          if (i_tx_valid) begin
            state_r <= ST_SHIFT;
            div_r   <= '0;
            cnt_r   <= '0;
            frame_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (div_r == DIV_LAST) begin
            div_r <= '0;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
              state_r    <= ST_DONE;
              frame_r    <= 1'b0;
              rx_valid_r <= 1'b1;
            end else begin
              state_r <= ST_SHIFT;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_DONE: begin
          // The rx register is complete here; latch it for holding
          rx_data_r  <= rx_par_s;
          rx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          frame_r    <= 1'b0;
          busy_r     <= 1'b0;
          rx_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // During the DONE strobe present the freshly completed word directly
  assign o_rx_data  = (state_r == ST_DONE) ? rx_par_s : rx_data_r;
  assign o_rx_valid = rx_valid_r;
  assign o_frame    = frame_r;
  assign o_busy     = busy_r;
  assign o_q        = frame_r & tx_ser_s;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Scoreboard bench for shift_frame_ctrl: a CLK_DIV=1 loopback instance and a CLK_DIV=3 instance with i_d tied high.
module tb_shift_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulses1 = 0;
  int pulses3 = 0;
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q3[$];
  logic [7:0] e1;
  logic [7:0] e3;

  logic       rst1, rst3;
  logic [7:0] tx_data1, tx_data3;
  logic       tx_valid1, tx_valid3;
  logic       ready1, ready3;
  logic       d1, d3;
  logic       q1, q3;
  logic       frame1, frame3;
  logic [7:0] rx_data1, rx_data3;
  logic       rx_valid1, rx_valid3;
  logic       busy1, busy3;

  assign d1 = q1;

  shift_frame_ctrl #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_tx_data(tx_data1), .i_tx_valid(tx_valid1),
    .o_tx_ready(ready1), .i_d(d1), .o_q(q1), .o_frame(frame1),
    .o_rx_data(rx_data1), .o_rx_valid(rx_valid1), .o_busy(busy1)
  );

  shift_frame_ctrl #(.DATA_W(8), .CLK_DIV(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_tx_data(tx_data3), .i_tx_valid(tx_valid3),
    .o_tx_ready(ready3), .i_d(d3), .o_q(q3), .o_frame(frame3),
    .o_rx_data(rx_data3), .o_rx_valid(rx_valid3), .o_busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bit_at(input logic [7:0] w, input int k);
`ifdef SHIFT_LSB_FIRST_EN
    return w[k];
`else
    return w[7-k];
`endif
  endfunction

  // Monitors: every rx_valid pulse must match the oldest expected word
  always @(negedge clk) begin
    if (rx_valid1 === 1'b1) begin
      pulses1++;
      tests++;
      if (exp_q1.size() == 0) begin
        fails++;
        $display("FAIL rx1_unexpected: got %0h, expected no pulse", rx_data1);
      end else begin
        e1 = exp_q1.pop_front();
        if (rx_data1 !== e1) begin
          fails++;
          $display("FAIL rx1_data: got %0h, expected %0h", rx_data1, e1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rx_valid3 === 1'b1) begin
      pulses3++;
      tests++;
      if (exp_q3.size() == 0) begin
        fails++;
        $display("FAIL rx3_unexpected: got %0h, expected no pulse", rx_data3);
      end else begin
        e3 = exp_q3.pop_front();
        if (rx_data3 !== e3) begin
          fails++;
          $display("FAIL rx3_data: got %0h, expected %0h", rx_data3, e3);
        end
      end
    end
  end

  task automatic send1(input logic [7:0] w);
    @(posedge clk); #1;
    tx_data1 = w; tx_valid1 = 1'b1;
    @(negedge clk);
    check("ready1_pre", 32'(ready1), 32'd1);
    @(posedge clk);
    exp_q1.push_back(w);
    #1; tx_valid1 = 1'b0; tx_data1 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("frame1_bit%0d", k), 32'(frame1), 32'd1);
      check($sformatf("q1_w%0h_bit%0d", w, k), 32'(q1), 32'(bit_at(w, k)));
      check($sformatf("busy1_bit%0d", k), 32'(busy1), 32'd1);
    end
    @(negedge clk);
    check("done1_frame", 32'(frame1), 32'd0);
    check("done1_q", 32'(q1), 32'd0);
    check("done1_valid", 32'(rx_valid1), 32'd1);
    check("done1_busy", 32'(busy1), 32'd1);
    check("done1_ready", 32'(ready1), 32'd0);
    @(negedge clk);
    check("post1_ready", 32'(ready1), 32'd1);
    check("post1_valid", 32'(rx_valid1), 32'd0);
    check("post1_busy", 32'(busy1), 32'd0);
  endtask

  task automatic send3(input logic [7:0] w);
    int frame_cnt;
    frame_cnt = 0;
    @(posedge clk); #1;
    tx_data3 = w; tx_valid3 = 1'b1;
    @(posedge clk);
    exp_q3.push_back(8'hFF);
    #1; tx_valid3 = 1'b0; tx_data3 = 8'h00;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (frame3 === 1'b1) frame_cnt++;
      check($sformatf("q3_cyc%0d", c), 32'(q3), 32'(bit_at(w, c / 3)));
    end
    @(negedge clk);
    if (frame3 === 1'b1) frame_cnt++;
    check("done3_valid", 32'(rx_valid3), 32'd1);
    check("done3_q", 32'(q3), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (frame3 === 1'b1) frame_cnt++;
    end
    check("frame3_len", 32'(frame_cnt), 32'd24);
    check("post3_ready", 32'(ready3), 32'd1);
    check("post3_rxdata", 32'(rx_data3), 32'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    tx_data1 = 8'h00; tx_data3 = 8'h00;
    tx_valid1 = 1'b0; tx_valid3 = 1'b0;
    d3 = 1'b1;

    @(posedge clk);
    @(negedge clk);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_ready3", 32'(ready3), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("rst_frame1", 32'(frame1), 32'd0);
    check("rst_q1", 32'(q1), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_valid1", 32'(rx_valid1), 32'd0);
    check("rst_rxdata1", 32'(rx_data1), 32'd0);
    check("rst_q3", 32'(q3), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);

    // Abort 0xF0 after four bits; the frame must vanish without a pulse
    @(posedge clk); #1;
    tx_data1 = 8'hF0; tx_valid1 = 1'b1;
    @(posedge clk); #1;
    tx_valid1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort_q_bit%0d", k), 32'(q1), 32'(bit_at(8'hF0, k)));
    end
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    @(negedge clk);
    check("abort_frame", 32'(frame1), 32'd0);
    check("abort_q", 32'(q1), 32'd0);
    check("abort_ready", 32'(ready1), 32'd1);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_rxdata", 32'(rx_data1), 32'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("abort_novalid%0d", c), 32'(rx_valid1), 32'd0);
    end
    send1(8'h3C);
    check("hold_3c", 32'(rx_data1), 32'h3C);

    send1(8'hA5);
    send1(8'h01);
    check("hold_01", 32'(rx_data1), 32'h01);

    send3(8'hC3);

    // Valid held high across two frames: one accept each, second at t+10
    @(posedge clk); #1;
    tx_data1 = 8'h11; tx_valid1 = 1'b1;
    @(negedge clk);
    check("hold_ready_pre", 32'(ready1), 32'd1);
    @(posedge clk);
    exp_q1.push_back(8'h11);
    #1; tx_data1 = 8'h22;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      check($sformatf("hold_ready1_c%0d", n), 32'(ready1), 32'd0);
    end
    @(negedge clk);
    check("hold_ready1_c10", 32'(ready1), 32'd1);
    @(posedge clk);
    exp_q1.push_back(8'h22);
    #1; tx_valid1 = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      check($sformatf("hold_ready2_c%0d", n), 32'(ready1), 32'd0);
    end
    @(negedge clk);
    check("hold_ready2_c10", 32'(ready1), 32'd1);
    for (int c = 0; c < 5; c++) @(negedge clk);

    check("pulses1", 32'(pulses1), 32'd5);
    check("pulses3", 32'(pulses3), 32'd1);
    check("pending1", 32'(exp_q1.size()), 32'd0);
    check("pending3", 32'(exp_q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
